// File: rtl/l2_tlb_miss_arbiter.sv
// L2 TLB miss arbiter: round-robin merges ITLB/DTLB misses into a single L2 lookup,
// escalates L2 misses to the PTW and routes the resulting refill back to the requesting L1.

package l2_tlb_pkg;
   localparam int unsigned DEFAULT_VLEN   = 39;
   localparam int unsigned PKG_ASID_WIDTH = 1;

   typedef struct packed {
      logic                      valid;
      logic                      is_2m;
      logic                      is_1g;
      logic [26:0]               vpn;
      logic [PKG_ASID_WIDTH-1:0] asid;
      logic [63:0]               content;
   } tlb_update_t;
endpackage

module l2_tlb_miss_arbiter #(
   parameter int unsigned VLEN       = l2_tlb_pkg::DEFAULT_VLEN,
   parameter int unsigned ASID_WIDTH = l2_tlb_pkg::PKG_ASID_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    itlb_miss_i,
   input  logic [VLEN-1:0]         itlb_vaddr_i,
   input  logic                    dtlb_miss_i,
   input  logic [VLEN-1:0]         dtlb_vaddr_i,
   output logic                    l2_lu_valid_o,
   output logic [VLEN-1:0]         l2_lu_vaddr_o,
   output logic                    l2_lu_is_itlb_o,
   input  logic                    l2_hit_i,
   input  l2_tlb_pkg::tlb_update_t l2_entry_i,
   output logic                    ptw_req_valid_o,
   output logic [VLEN-1:0]         ptw_req_vaddr_o,
   output logic                    ptw_req_is_itlb_o,
   input  logic                    ptw_req_ready_i,
   input  l2_tlb_pkg::tlb_update_t ptw_update_i,
   input  logic                    ptw_error_i,
   output l2_tlb_pkg::tlb_update_t itlb_update_o,
   output l2_tlb_pkg::tlb_update_t dtlb_update_o,
   output logic                    itlb_err_o,
   output logic                    dtlb_err_o,
   output logic                    busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      PTW_REQ,
      PTW_WAIT,
      REFILL
   } state_e;

   state_e                  state_q, state_d;
   logic [VLEN-1:0]         req_vaddr_q, req_vaddr_d;
   logic                    req_itlb_q, req_itlb_d;
   logic                    last_grant_itlb_q, last_grant_itlb_d;
   l2_tlb_pkg::tlb_update_t refill_q, refill_d;
   logic                    any_miss;
   logic                    grant_itlb;

   if (ASID_WIDTH != l2_tlb_pkg::PKG_ASID_WIDTH) begin : g_asid_width_check
      $error("ASID_WIDTH must match the asid field of tlb_update_t");
   end

   // On a tie the side that was not granted last time wins.
   assign any_miss   = itlb_miss_i | dtlb_miss_i;
   assign grant_itlb = itlb_miss_i & (~dtlb_miss_i | ~last_grant_itlb_q);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every register here is reset; there is no storage array, so nothing is left unreset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_vaddr_q       <= '0;
         req_itlb_q        <= 1'b0;
         last_grant_itlb_q <= 1'b0;
         refill_q          <= '0;
      end else begin
         req_vaddr_q       <= req_vaddr_d;
         req_itlb_q        <= req_itlb_d;
         last_grant_itlb_q <= last_grant_itlb_d;
         refill_q          <= refill_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d           = state_q;
      req_vaddr_d       = req_vaddr_q;
      req_itlb_d        = req_itlb_q;
      last_grant_itlb_d = last_grant_itlb_q;
      refill_d          = refill_q;

      if (flush_i) begin
         // Flush wins over any hit, completion or error seen in the same cycle.
         state_d  = IDLE;
         refill_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_miss) begin
                  state_d           = LOOKUP;
                  req_itlb_d        = grant_itlb;
                  req_vaddr_d       = grant_itlb ? itlb_vaddr_i : dtlb_vaddr_i;
                  last_grant_itlb_d = grant_itlb;
               end
            end
            LOOKUP: begin
               if (l2_hit_i) begin
                  refill_d = l2_entry_i;
                  state_d  = REFILL;
               end else begin
                  state_d = PTW_REQ;
               end
            end
            PTW_REQ: begin
               if (ptw_req_ready_i) begin
                  state_d = PTW_WAIT;
               end
            end
            PTW_WAIT: begin
               if (ptw_error_i) begin
                  state_d = IDLE;
               end else if (ptw_update_i.valid) begin
                  refill_d = ptw_update_i;
                  state_d  = REFILL;
               end
            end
            REFILL:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      l2_lu_valid_o       = 1'b0;
      ptw_req_valid_o     = 1'b0;
      itlb_update_o       = refill_q;
      dtlb_update_o       = refill_q;
      itlb_update_o.valid = 1'b0;
      dtlb_update_o.valid = 1'b0;
      itlb_err_o          = 1'b0;
      dtlb_err_o          = 1'b0;

      case (state_q)
         LOOKUP:  l2_lu_valid_o   = 1'b1;
         PTW_REQ: ptw_req_valid_o = 1'b1;
         PTW_WAIT: begin
            if (ptw_error_i && !flush_i) begin
               itlb_err_o = req_itlb_q;
               dtlb_err_o = ~req_itlb_q;
            end
         end
         REFILL: begin
            if (!flush_i) begin
               itlb_update_o.valid = req_itlb_q;
               dtlb_update_o.valid = ~req_itlb_q;
            end
         end
         default: ;
      endcase
   end

   assign l2_lu_vaddr_o     = req_vaddr_q;
   assign l2_lu_is_itlb_o   = req_itlb_q;
   assign ptw_req_vaddr_o   = req_vaddr_q;
   assign ptw_req_is_itlb_o = req_itlb_q;
   assign busy_o            = (state_q != IDLE);

endmodule
